// File: rtl/note_event_scheduler_if.sv
// Event handshake between the note scheduler (master) and the audio note consumer (slave).
interface note_event_scheduler_if;
    logic       event_valid_out;
    logic [3:0] event_note_out;
    logic       event_on_out;
    logic       event_ready_in;

    modport master (
        output event_valid_out,
        output event_note_out,
        output event_on_out,
        input  event_ready_in
    );

    modport slave (
        input  event_valid_out,
        input  event_note_out,
        input  event_on_out,
        output event_ready_in
    );
endinterface

// File: rtl/note_event_scheduler.sv
// Debounces per-frame key codes and emits ordered note-off / note-on events over valid/ready.
module note_event_scheduler #(
    parameter int unsigned STABLE_FRAMES = 3
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic [3:0]                    note_in,
    input  logic                          frame_valid_in,
    note_event_scheduler_if.master        evt,
    output logic [3:0]                    active_note_out,
    output logic                          busy_out
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StOff  = 2'd1;
    localparam logic [1:0] StOn   = 2'd2;

    localparam logic [3:0] SfVal = 4'(STABLE_FRAMES);

    logic [3:0] cand_q, cand_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] target_q, target_d;
    logic [3:0] active_q, active_d;
    logic [1:0] state_q, state_d;
    logic       valid_q, valid_d;
    logic [3:0] note_q, note_d;
    logic       on_q, on_d;
    logic       busy_q, busy_d;
    logic [3:0] note_san;
    logic       hs;

    // Codes 13..15 cannot come from a real key; treat them as silence.
    assign note_san = (note_in > 4'd12) ? 4'd0 : note_in;
    assign hs       = valid_q && evt.event_ready_in;

    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        if (frame_valid_in) begin
            if (note_san == cand_q) begin
                cnt_d = (cnt_q >= SfVal) ? SfVal : cnt_q + 4'd1;
            end else begin
                cand_d = note_san;
                cnt_d  = 4'd1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        active_d = active_q;
        valid_d  = valid_q;
        note_d   = note_q;
        on_d     = on_q;
        case (state_q)
            StIdle: begin
                if ((cnt_q == SfVal) && (cand_q != active_q)) begin
                    target_d = cand_q;
                    valid_d  = 1'b1;
                    if (active_q != 4'd0) begin
                        state_d = StOff;
                        note_d  = active_q;
                        on_d    = 1'b0;
                    end else begin
                        state_d = StOn;
                        note_d  = cand_q;
                        on_d    = 1'b1;
                    end
                end
            end
            StOff: begin
                if (hs) begin
                    active_d = 4'd0;
                    if (target_q != 4'd0) begin
                        state_d = StOn;
                        note_d  = target_q;
                        on_d    = 1'b1;
                    end else begin
                        state_d = StIdle;
                        valid_d = 1'b0;
                        note_d  = 4'd0;
                        on_d    = 1'b0;
                    end
                end
            end
            StOn: begin
                if (hs) begin
                    active_d = target_q;
                    state_d  = StIdle;
                    valid_d  = 1'b0;
                    note_d   = 4'd0;
                    on_d     = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                valid_d = 1'b0;
                note_d  = 4'd0;
                on_d    = 1'b0;
            end
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cand_q   <= 4'd0;
            cnt_q    <= 4'd0;
            target_q <= 4'd0;
            active_q <= 4'd0;
            state_q  <= StIdle;
            valid_q  <= 1'b0;
            note_q   <= 4'd0;
            on_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
            active_q <= active_d;
            state_q  <= state_d;
            valid_q  <= valid_d;
            note_q   <= note_d;
            on_q     <= on_d;
            busy_q   <= busy_d;
        end
    end

    assign evt.event_valid_out = valid_q;
    assign evt.event_note_out  = note_q;
    assign evt.event_on_out    = on_q;
    assign active_note_out     = active_q;
    assign busy_out            = busy_q;

endmodule

// File: tb/tb_note_event_scheduler.sv
// Scenario bench for note_event_scheduler: expected events queued at stimulus, compared on transfer.
module tb_note_event_scheduler;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic [3:0] note_in;
    logic       frame_valid_in;
    logic [3:0] active_note_out;
    logic       busy_out;

    int checks   = 0;
    int failures = 0;

    logic [4:0] exp_q[$];
    logic [4:0] obs_q[$];

    note_event_scheduler_if evt_if ();

    note_event_scheduler #(.STABLE_FRAMES(3)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .note_in         (note_in),
        .frame_valid_in  (frame_valid_in),
        .evt             (evt_if),
        .active_note_out (active_note_out),
        .busy_out        (busy_out)
    );

    always #5 clk_in = ~clk_in;

    // Record every completed transfer as {note, on}.
    always @(negedge clk_in) begin
        if (rst_in && evt_if.event_valid_out && evt_if.event_ready_in)
            obs_q.push_back({evt_if.event_note_out, evt_if.event_on_out});
    end

    task automatic drive_frame(input logic [3:0] n);
        @(posedge clk_in); #1;
        note_in = n;
        frame_valid_in = 1'b1;
        @(posedge clk_in); #1;
        frame_valid_in = 1'b0;
    endtask

    task automatic test_reset;
        rst_in = 1'b0;
        note_in = 4'd0;
        frame_valid_in = 1'b0;
        evt_if.event_ready_in = 1'b0;
        repeat (2) @(negedge clk_in);
        checks += 5;
        if (evt_if.event_valid_out !== 1'b0) begin
            failures++; $display("FAIL reset_valid got=%b want=0", evt_if.event_valid_out);
        end
        if (evt_if.event_note_out !== 4'd0) begin
            failures++; $display("FAIL reset_note got=%0d want=0", evt_if.event_note_out);
        end
        if (evt_if.event_on_out !== 1'b0) begin
            failures++; $display("FAIL reset_on got=%b want=0", evt_if.event_on_out);
        end
        if (active_note_out !== 4'd0) begin
            failures++; $display("FAIL reset_active got=%0d want=0", active_note_out);
        end
        if (busy_out !== 1'b0) begin
            failures++; $display("FAIL reset_busy got=%b want=0", busy_out);
        end
        @(posedge clk_in); #1;
        rst_in = 1'b1;
    endtask

    task automatic test_clean_press;
        logic [4:0] e, o;
        evt_if.event_ready_in = 1'b1;
        exp_q.push_back({4'd5, 1'b1});
        repeat (3) drive_frame(4'd5);
        @(negedge clk_in);
        checks++;
        if (evt_if.event_valid_out !== 1'b0) begin
            failures++; $display("FAIL press_early_valid got=%b want=0", evt_if.event_valid_out);
        end
        @(negedge clk_in);
        checks++;
        if ({evt_if.event_valid_out, evt_if.event_note_out, evt_if.event_on_out} !== {1'b1, 4'd5, 1'b1}) begin
            failures++;
            $display("FAIL press_latency got=v%b n%0d o%b want=v1 n5 o1",
                     evt_if.event_valid_out, evt_if.event_note_out, evt_if.event_on_out);
        end
        repeat (6) @(negedge clk_in);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin
                failures++; $display("FAIL press_event got=none want=%0d/%b", e[4:1], e[0]);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    failures++; $display("FAIL press_event got=%0d/%b want=%0d/%b", o[4:1], o[0], e[4:1], e[0]);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++; $display("FAIL press_extra got=%0d want=0", obs_q.size()); obs_q.delete();
        end
        checks++;
        if (active_note_out !== 4'd5) begin
            failures++; $display("FAIL press_active got=%0d want=5", active_note_out);
        end
    endtask

    task automatic test_glitch;
        logic [3:0] seq [6];
        seq = '{4'd5, 4'd8, 4'd8, 4'd5, 4'd5, 4'd5};
        for (int i = 0; i < 6; i++) drive_frame(seq[i]);
        for (int i = 0; i < 16; i++) drive_frame(4'd5);
        repeat (4) @(negedge clk_in);
        checks += 3;
        if (obs_q.size() != 0) begin
            failures++; $display("FAIL glitch_events got=%0d want=0", obs_q.size()); obs_q.delete();
        end
        if (active_note_out !== 4'd5) begin
            failures++; $display("FAIL glitch_active got=%0d want=5", active_note_out);
        end
        if (busy_out !== 1'b0) begin
            failures++; $display("FAIL glitch_busy got=%b want=0", busy_out);
        end
    endtask

    task automatic test_backpressure;
        logic [4:0] e, o;
        @(posedge clk_in); #1;
        evt_if.event_ready_in = 1'b0;
        exp_q.push_back({4'd5, 1'b0});
        exp_q.push_back({4'd8, 1'b1});
        repeat (3) drive_frame(4'd8);
        repeat (2) @(negedge clk_in);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({evt_if.event_valid_out, evt_if.event_note_out, evt_if.event_on_out,
                 active_note_out} !== {1'b1, 4'd5, 1'b0, 4'd5}) begin
                failures++;
                $display("FAIL bp_hold[%0d] got=v%b n%0d o%b a%0d want=v1 n5 o0 a5", i,
                         evt_if.event_valid_out, evt_if.event_note_out, evt_if.event_on_out,
                         active_note_out);
            end
            @(negedge clk_in);
        end
        @(posedge clk_in); #1;
        evt_if.event_ready_in = 1'b1;
        repeat (2) @(negedge clk_in);
        checks++;
        if ({evt_if.event_valid_out, evt_if.event_note_out, evt_if.event_on_out,
             active_note_out} !== {1'b1, 4'd8, 1'b1, 4'd0}) begin
            failures++;
            $display("FAIL bp_on_next got=v%b n%0d o%b a%0d want=v1 n8 o1 a0",
                     evt_if.event_valid_out, evt_if.event_note_out, evt_if.event_on_out,
                     active_note_out);
        end
        @(negedge clk_in);
        checks++;
        if ({evt_if.event_valid_out, active_note_out} !== {1'b0, 4'd8}) begin
            failures++;
            $display("FAIL bp_done got=v%b a%0d want=v0 a8", evt_if.event_valid_out, active_note_out);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin
                failures++; $display("FAIL bp_event got=none want=%0d/%b", e[4:1], e[0]);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    failures++; $display("FAIL bp_event got=%0d/%b want=%0d/%b", o[4:1], o[0], e[4:1], e[0]);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++; $display("FAIL bp_extra got=%0d want=0", obs_q.size()); obs_q.delete();
        end
    endtask

    task automatic test_release_illegal;
        logic [4:0] e, o;
        exp_q.push_back({4'd8, 1'b0});
        repeat (3) drive_frame(4'd14);
        repeat (6) @(negedge clk_in);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin
                failures++; $display("FAIL release_event got=none want=%0d/%b", e[4:1], e[0]);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    failures++; $display("FAIL release_event got=%0d/%b want=%0d/%b", o[4:1], o[0], e[4:1], e[0]);
                end
            end
        end
        checks += 3;
        if (obs_q.size() != 0) begin
            failures++; $display("FAIL release_extra got=%0d want=0", obs_q.size()); obs_q.delete();
        end
        if (active_note_out !== 4'd0) begin
            failures++; $display("FAIL release_active got=%0d want=0", active_note_out);
        end
        if (busy_out !== 1'b0) begin
            failures++; $display("FAIL release_busy got=%b want=0", busy_out);
        end
    endtask

    task automatic test_busy_change;
        logic [4:0] e, o;
        @(posedge clk_in); #1;
        evt_if.event_ready_in = 1'b0;
        exp_q.push_back({4'd3, 1'b1});
        exp_q.push_back({4'd3, 1'b0});
        exp_q.push_back({4'd10, 1'b1});
        repeat (3) drive_frame(4'd3);
        repeat (3) drive_frame(4'd10);
        @(negedge clk_in);
        checks += 2;
        if ({evt_if.event_valid_out, evt_if.event_note_out, evt_if.event_on_out} !== {1'b1, 4'd3, 1'b1}) begin
            failures++;
            $display("FAIL busy_stalled_on got=v%b n%0d o%b want=v1 n3 o1",
                     evt_if.event_valid_out, evt_if.event_note_out, evt_if.event_on_out);
        end
        if (busy_out !== 1'b1) begin
            failures++; $display("FAIL busy_flag got=%b want=1", busy_out);
        end
        @(posedge clk_in); #1;
        evt_if.event_ready_in = 1'b1;
        repeat (8) @(negedge clk_in);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin
                failures++; $display("FAIL busy_event got=none want=%0d/%b", e[4:1], e[0]);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    failures++; $display("FAIL busy_event got=%0d/%b want=%0d/%b", o[4:1], o[0], e[4:1], e[0]);
                end
            end
        end
        checks += 2;
        if (obs_q.size() != 0) begin
            failures++; $display("FAIL busy_extra got=%0d want=0", obs_q.size()); obs_q.delete();
        end
        if (active_note_out !== 4'd10) begin
            failures++; $display("FAIL busy_active got=%0d want=10", active_note_out);
        end
    endtask

    task automatic test_back_to_back;
        logic [4:0] e, o;
        exp_q.push_back({4'd10, 1'b0});
        exp_q.push_back({4'd2, 1'b1});
        repeat (3) drive_frame(4'd2);
        repeat (2) @(negedge clk_in);
        checks++;
        if ({evt_if.event_valid_out, evt_if.event_note_out, evt_if.event_on_out} !== {1'b1, 4'd10, 1'b0}) begin
            failures++;
            $display("FAIL b2b_off got=v%b n%0d o%b want=v1 n10 o0",
                     evt_if.event_valid_out, evt_if.event_note_out, evt_if.event_on_out);
        end
        @(negedge clk_in);
        checks++;
        if ({evt_if.event_valid_out, evt_if.event_note_out, evt_if.event_on_out} !== {1'b1, 4'd2, 1'b1}) begin
            failures++;
            $display("FAIL b2b_on got=v%b n%0d o%b want=v1 n2 o1",
                     evt_if.event_valid_out, evt_if.event_note_out, evt_if.event_on_out);
        end
        repeat (4) @(negedge clk_in);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin
                failures++; $display("FAIL b2b_event got=none want=%0d/%b", e[4:1], e[0]);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    failures++; $display("FAIL b2b_event got=%0d/%b want=%0d/%b", o[4:1], o[0], e[4:1], e[0]);
                end
            end
        end
        checks += 2;
        if (obs_q.size() != 0) begin
            failures++; $display("FAIL b2b_extra got=%0d want=0", obs_q.size()); obs_q.delete();
        end
        if (active_note_out !== 4'd2) begin
            failures++; $display("FAIL b2b_active got=%0d want=2", active_note_out);
        end
    endtask

    task automatic test_reset_mid_event;
        repeat (3) drive_frame(4'd5);
        repeat (6) @(negedge clk_in);
        obs_q.delete();
        @(posedge clk_in); #1;
        evt_if.event_ready_in = 1'b0;
        repeat (3) drive_frame(4'd7);
        repeat (2) @(negedge clk_in);
        checks++;
        if ({evt_if.event_valid_out, evt_if.event_note_out, evt_if.event_on_out} !== {1'b1, 4'd5, 1'b0}) begin
            failures++;
            $display("FAIL rstmid_pending got=v%b n%0d o%b want=v1 n5 o0",
                     evt_if.event_valid_out, evt_if.event_note_out, evt_if.event_on_out);
        end
        #2;
        rst_in = 1'b0;
        #1;
        checks++;
        if ({evt_if.event_valid_out, evt_if.event_note_out, evt_if.event_on_out,
             active_note_out, busy_out} !== 11'd0) begin
            failures++;
            $display("FAIL rstmid_async got=v%b n%0d o%b a%0d b%b want=all 0",
                     evt_if.event_valid_out, evt_if.event_note_out, evt_if.event_on_out,
                     active_note_out, busy_out);
        end
        @(posedge clk_in); #1;
        rst_in = 1'b1;
        evt_if.event_ready_in = 1'b1;
        repeat (3) drive_frame(4'd0);
        repeat (6) @(negedge clk_in);
        checks += 2;
        if (obs_q.size() != 0) begin
            failures++; $display("FAIL rstmid_events got=%0d want=0", obs_q.size()); obs_q.delete();
        end
        if (active_note_out !== 4'd0) begin
            failures++; $display("FAIL rstmid_active got=%0d want=0", active_note_out);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_glitch();
        test_backpressure();
        test_release_illegal();
        test_busy_change();
        test_back_to_back();
        test_reset_mid_event();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/note_event_scheduler.md
# note_event_scheduler

Sequences the per-frame key classification into discrete note-on/note-off events for the synthesis side of the piano. Its input is the 4-bit note code produced by key association, sampled once per video frame on a strobe. The block debounces that code across consecutive frames and tracks the single currently sounding note. It emits ordered OFF-then-ON events through a valid/ready handshake. It sits between the top-camera key-association stage and the audio note consumer.

## Interface
- STABLE_FRAMES, default 3: consecutive identical frames needed to confirm a note change; legal range 1..15.
- clk_in  input  1  system clock.
- rst_in  input  1  reset, asynchronous, active-low.
- note_in  input  4  note code from key association: 0 means none, 1..12 means C..B, and 13..15 are illegal.
- frame_valid_in  input  1  single-cycle strobe; note_in is valid in this cycle.
- event_ready_in  input  1  consumer accepts the event when high together with event_valid_out.
- event_valid_out  output  1  an event is presented.
- event_note_out  output  4  note of the presented event, 1..12.
- event_on_out  output  1  1 = note-on, 0 = note-off.
- active_note_out  output  4  currently confirmed note, 0 = silent.
- busy_out  output  1  FSM is not in IDLE.

## Operation
- Input sanitising: note_in values 13..15 are treated as 0.
- Debounce registers:
  - cand: 4 bits.
  - cnt: 4 bits, saturating at STABLE_FRAMES.
- On each frame_valid_in cycle:
  - If sanitised note == cand, cnt <= min(cnt+1, STABLE_FRAMES).
  - Otherwise, cand <= note and cnt <= 1.
- Debouncing runs every cycle, independent of the FSM state.
- Confirm condition: (cnt == STABLE_FRAMES) && (cand != active). The condition is level-based and is evaluated only in IDLE.
- FSM states and transitions:
  - IDLE: if the confirm condition holds, latch target <= cand. Then go to OFF if active != 0, otherwise go to ON. If not, stay in IDLE.
  - OFF: present {note=active, on=0}. On handshake, set active <= 0. Then go to ON if target != 0, otherwise go to IDLE.
  - ON: present {note=target, on=1}. On handshake, set active <= target and go to IDLE.
- Handshake: an event transfers in a cycle where event_valid_out && event_ready_in.
  - While valid is high and ready is low, note, on and valid hold stable.
  - Valid is never withdrawn before the transfer completes.
- Changes of cand while the FSM is in OFF or ON do not alter target. After returning to IDLE, the confirm condition is re-checked against the new cand.
- A change straight from note A to note B always produces OFF(A) followed by ON(B), never overlapping.
- A change from A to 0 produces only OFF(A). A change from 0 to B produces only ON(B).
- A glitch shorter than STABLE_FRAMES frames produces no event.

## Timing
- Reset values (asynchronous, all outputs):
  - cand = 0, cnt = 0, active_note_out = 0, target = 0.
  - FSM = IDLE, event_valid_out = 0, event_note_out = 0, event_on_out = 0, busy_out = 0.
- All outputs are registered.
- Latency, with frame strobe at cycle t making cnt reach STABLE_FRAMES:
  - cnt updates at edge t+1.
  - The FSM leaves IDLE at edge t+2.
  - event_valid_out is high from cycle t+2.
- With ready held high:
  - OFF transfers in its first valid cycle, and ON is valid in the next cycle.
  - active_note_out updates at the edge ending each transfer cycle.
- Back-to-back transfers are supported: one event per cycle maximum.
- A frame strobe coinciding with a handshake is applied normally. Both register updates take effect at the same edge.
- If rst_in is asserted mid-event, the event is dropped silently and valid falls asynchronously. After release, the block restarts from silent with no OFF emitted.
- With STABLE_FRAMES = 1, every differing frame confirms on the strobe that carries it.

## Test plan
- **Clean press:** after reset, apply 3 frames of note_in=5 with ready=1.
  - Single event {5, on}, valid rising 2 cycles after the 3rd strobe.
  - active_note_out=5 afterwards.
- **Glitch reject:** with 5 active, apply frames 5, 8, 8, 5, 5, 5.
  - No event.
  - active_note_out stays 5.
  - cnt saturates without overflow.
- **Note change with backpressure:** with 5 active, apply 3 frames of 8 while ready=0 for 10 cycles.
  - {5, off} is held stable for 10 cycles, then transfers.
  - {8, on} follows in the next cycle.
  - active_note_out goes 5→0→8.
- **Release and illegal code:** with 8 active, apply 3 frames of note_in=14.
  - Treated as 0: only {8, off} is emitted.
  - active_note_out=0 and busy_out ends at 0.
- **Change during busy:** while ON(3) is stalled, apply 3 frames of 10.
  - ON(3) completes first.
  - Then OFF(3) and ON(10) are emitted in order.
- **Reset mid-event:** assert rst_in while OFF(5) is pending.
  - All outputs return to 0 immediately.
  - After release, 3 frames of 0 produce no events.
